ysyx_22050854_imm_enc: RTL

Streaming RISC-V instruction encoder, the inverse of the immediate generator: it packs a 64-bit immediate plus register/opcode fields into a 32-bit instruction word. It uses the same 3-bit format code (ExtOP encoding) as the decode side. Used by the self-test/trampoline generator to build instruction words at run time. It has a valid/ready input, a one-entry registered output, per-beat range checking and an optional two-beat ADDI expansion.

---
 rtl/ysyx_22050854_imm_enc.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22050854_imm_enc.sv
// ysyx_22050854_imm_enc: streaming RISC-V instruction encoder.
// Packs a 64-bit immediate plus opcode/register fields into a 32-bit word
// using the 3-bit ExtOP format code. It has one registered output entry with
// valid/ready on both sides, and it range-checks each beat.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready command handshake (in_ready is combinational on out_ready)
//   in_fmt            000 I, 001 U, 010 S, 011 B, 100 J, 101 raw7, 11x illegal
//   in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm   command fields
//   out_valid/out_ready  output beat handshake
//   out_instr, out_last, out_err  encoded beat, final-beat flag, error flag
//   err_cnt           saturating count of completed error beats
//
// Optional feature: define YSYX_22050854_IMM_ENC_SPLIT_EN to expand an
// out-of-range ADDI into a LUI + ADDI pair.
module ysyx_22050854_imm_enc #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_funct3,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [63:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_last,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned INSTR_W = 32;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  typedef enum logic [1:0] {
`ifdef YSYX_22050854_IMM_ENC_SPLIT_EN
    S_FULL_PEND = 2'd2,
`endif
    S_EMPTY     = 2'd0,
    S_FULL      = 2'd1
  } state_t;

  state_t               state, state_n;
  logic                 valid_q, valid_n;
  logic [INSTR_W-1:0]   instr_q, instr_n;
  logic                 last_q, last_n;
  logic                 err_q, err_n;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_n;

  logic [INSTR_W-1:0]   enc_instr;
  logic                 enc_err;
  logic                 enc_last;
  logic                 fit12, fit13, fit21, fit32;
  logic                 accept;

`ifdef YSYX_22050854_IMM_ENC_SPLIT_EN
  logic [INSTR_W-1:0]   pend_q, pend_n;
  logic                 enc_split;
  logic                 split_win;
  logic [19:0]          lui_hi;
  logic [INSTR_W-1:0]   enc_pend;
`endif

  // Signed-fit checks: the immediate equals the sign extension of its low bits.
  assign fit12 = (in_imm == {{52{in_imm[11]}}, in_imm[11:0]});
  assign fit13 = (in_imm == {{51{in_imm[12]}}, in_imm[12:0]});
  assign fit21 = (in_imm == {{43{in_imm[20]}}, in_imm[20:0]});
  assign fit32 = (in_imm == {{32{in_imm[31]}}, in_imm[31:0]});

  assign in_ready = (state == S_EMPTY) || ((state == S_FULL) && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef YSYX_22050854_IMM_ENC_SPLIT_EN
  // The upper bound leaves room for the +1 carry of imm[11] into the LUI part.
  assign split_win = fit32 && (in_imm[31] || (in_imm[30:0] <= 31'h7FFF_F7FF));
  assign lui_hi    = in_imm[31:12] + 20'(in_imm[11]);
  assign enc_pend  = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_ADDI};
`endif

  // Format encoder and range check for the incoming command.
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    enc_last  = 1'b1;
`ifdef YSYX_22050854_IMM_ENC_SPLIT_EN
    enc_split = 1'b0;
`endif
    case (in_fmt)
      3'b000: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = !fit12;
      end
      3'b001: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = (in_imm[11:0] != 12'd0) || !fit32;
      end
      3'b010: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = !fit12;
      end
      3'b011: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = in_imm[0] || !fit13;
      end
      3'b100: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = in_imm[0] || !fit21;
      end
      3'b101: begin
        enc_instr = {25'd0, in_imm[6:0]};
        enc_err   = |in_imm[63:7];
      end
      default: begin
        enc_instr = '0;
        enc_err   = 1'b1;
      end
    endcase
`ifdef YSYX_22050854_IMM_ENC_SPLIT_EN
    // Out-of-range ADDI inside the window becomes LUI now, ADDI next beat.
    if ((in_fmt == 3'b000) && (in_opcode == OP_ADDI) && (in_funct3 == 3'b000) &&
        !fit12 && split_win) begin
      enc_instr = {lui_hi, in_rd, OP_LUI};
      enc_err   = 1'b0;
      enc_last  = 1'b0;
      enc_split = 1'b1;
    end
`endif
  end

  // Next-state and output-register logic.
  always_comb begin
    state_n = state;
    valid_n = valid_q;
    instr_n = instr_q;
    last_n  = last_q;
    err_n   = err_q;
    cnt_n   = cnt_q;
`ifdef YSYX_22050854_IMM_ENC_SPLIT_EN
    pend_n  = pend_q;
`endif
    if (valid_q && out_ready && err_q && (cnt_q != '1)) begin
      cnt_n = cnt_q + ERR_CNT_W'(1);
    end
    case (state)
      S_EMPTY, S_FULL: begin
        if (accept) begin
          valid_n = 1'b1;
          instr_n = enc_instr;
          last_n  = enc_last;
          err_n   = enc_err;
          state_n = S_FULL;
`ifdef YSYX_22050854_IMM_ENC_SPLIT_EN
          if (enc_split) begin
            state_n = S_FULL_PEND;
            pend_n  = enc_pend;
          end
`endif
        end else if ((state == S_FULL) && out_ready) begin
          valid_n = 1'b0;
          state_n = S_EMPTY;
        end
      end
`ifdef YSYX_22050854_IMM_ENC_SPLIT_EN
      S_FULL_PEND: begin
        if (out_ready) begin
          instr_n = pend_q;
          last_n  = 1'b1;
          err_n   = 1'b0;
          state_n = S_FULL;
        end
      end
`endif
      default: begin
        valid_n = 1'b0;
        state_n = S_EMPTY;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_EMPTY;
      valid_q <= 1'b0;
      instr_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef YSYX_22050854_IMM_ENC_SPLIT_EN
      pend_q  <= '0;
`endif
    end else begin
      state   <= state_n;
      valid_q <= valid_n;
      instr_q <= instr_n;
      last_q  <= last_n;
      err_q   <= err_n;
      cnt_q   <= cnt_n;
`ifdef YSYX_22050854_IMM_ENC_SPLIT_EN
      pend_q  <= pend_n;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_last  = last_q;
  assign out_err   = err_q;
  assign err_cnt   = cnt_q;

endmodule
